// File: rtl/cnt100_seq_ctrl_pkg.sv
// Shared definitions for the modulo-100 count sequencer: FSM encoding and default sizing.
package cnt100_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int DEF_MAX_CNT = 99;
  localparam int DEF_CNT_W   = 7;
  localparam int PRESC_W     = 8;

endpackage

// File: rtl/cnt100_core.sv
// Modulo-(MAX_CNT+1) counter datapath with synchronous clear (wins over increment).
module cnt100_core
  import cnt100_seq_ctrl_pkg::*;
#(
  parameter int MAX_CNT = DEF_MAX_CNT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_en,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt
);

  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX_CNT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = (cnt_q == MAX_V) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt = cnt_q;

endmodule

// File: rtl/cnt100_seq_ctrl.sv
// Job sequencer: accepts a target over valid/ready, steps the core counter once per
// PRESCALE clocks until the target, with pause/abort and one-cycle done/err pulses.
module cnt100_seq_ctrl
  import cnt100_seq_ctrl_pkg::*;
#(
  parameter int MAX_CNT  = DEF_MAX_CNT,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  output logic             o_ready,
  input  logic [CNT_W-1:0] i_target,
  input  logic             i_pause,
  input  logic             i_abort,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err
);

  localparam logic [CNT_W-1:0]   MAX_V   = CNT_W'(MAX_CNT);
  localparam logic [PRESC_W-1:0] PS_LAST = PRESC_W'(PRESCALE - 1);

  state_e             state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [CNT_W-1:0]   target_q, target_d;
  logic               err_q, err_d;
  logic               cnt_en, cnt_clr;
  logic               tick;

  assign tick = (presc_q == PS_LAST);

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    target_d = target_q;
    err_d    = 1'b0;
    cnt_en   = 1'b0;
    cnt_clr  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          cnt_clr  = 1'b1;
          target_d = i_target;
          if (i_target > MAX_V) begin
            err_d = 1'b1;
          end else begin
            state_d = ST_RUN;
            presc_d = '0;
          end
        end
      end
      // PAUSE resumes and may tick in the same cycle i_pause drops, so each
      // paused cycle costs exactly one cycle of latency.
      ST_RUN, ST_PAUSE: begin
        if (i_abort) begin
          state_d = ST_IDLE;
          presc_d = '0;
          cnt_clr = 1'b1;
        end else if (i_pause) begin
          state_d = ST_PAUSE;
        end else begin
          state_d = ST_RUN;
          if (tick) begin
            presc_d = '0;
            if (o_cnt == target_q) begin
              state_d = ST_DONE;
            end else begin
              cnt_en = 1'b1;
            end
          end else begin
            presc_d = presc_q + PRESC_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (i_abort) begin
          presc_d = '0;
          cnt_clr = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      presc_q  <= '0;
      target_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      target_q <= target_d;
      err_q    <= err_d;
    end
  end

  cnt100_core #(
    .MAX_CNT (MAX_CNT),
    .CNT_W   (CNT_W)
  ) u_core (
    .clk   (clk),
    .reset (reset),
    .i_en  (cnt_en),
    .i_clr (cnt_clr),
    .o_cnt (o_cnt)
  );

  assign o_ready = (state_q == ST_IDLE);
  assign o_busy  = (state_q == ST_RUN) || (state_q == ST_PAUSE);
  assign o_done  = (state_q == ST_DONE);
  assign o_err   = err_q;

endmodule

// File: tb/tb_cnt100_seq_ctrl.sv
// Directed bench for cnt100_seq_ctrl: one instance at PRESCALE=1, one at PRESCALE=3.
module tb_cnt100_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start1, pause1, abort1, ready1, busy1, done1, err1;
  logic [6:0] target1, cnt1;
  logic       start3, pause3, abort3, ready3, busy3, done3, err3;
  logic [6:0] target3, cnt3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cnt100_seq_ctrl #(.MAX_CNT(99), .CNT_W(7), .PRESCALE(1)) u_p1 (
    .clk(clk), .reset(reset), .i_start(start1), .o_ready(ready1), .i_target(target1),
    .i_pause(pause1), .i_abort(abort1), .o_cnt(cnt1), .o_busy(busy1), .o_done(done1),
    .o_err(err1)
  );

  cnt100_seq_ctrl #(.MAX_CNT(99), .CNT_W(7), .PRESCALE(3)) u_p3 (
    .clk(clk), .reset(reset), .i_start(start3), .o_ready(ready3), .i_target(target3),
    .i_pause(pause3), .i_abort(abort3), .o_cnt(cnt3), .o_busy(busy3), .o_done(done3),
    .o_err(err3)
  );

  typedef struct {
    logic       start;
    logic [6:0] target;
    logic       pause;
    logic       abort;
    logic [6:0] e_cnt;
    logic       e_rdy;
    logic       e_busy;
    logic       e_done;
    logic       e_err;
  } vec_t;

  function automatic vec_t mk(input int s, input int t, input int p, input int a,
                              input int c, input int r, input int b, input int d,
                              input int e);
    vec_t v;
    v.start  = s[0];
    v.target = t[6:0];
    v.pause  = p[0];
    v.abort  = a[0];
    v.e_cnt  = c[6:0];
    v.e_rdy  = r[0];
    v.e_busy = b[0];
    v.e_done = d[0];
    v.e_err  = e[0];
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // P=1 job with a 4-cycle pause starting when o_cnt reaches pause_at.
  task automatic pause_job(input int t, input int pause_at, input string nm);
    int  cyc;
    int  plen;
    int  frozen_bad;
    start1  = 1'b1;
    target1 = 7'(t);
    step();
    start1 = 1'b0;
    cyc = 0;
    plen = 0;
    frozen_bad = 0;
    while (!done1 && cyc < 200) begin
      pause1 = (int'(cnt1) == pause_at) && (plen < 4);
      step();
      cyc++;
      if (pause1) begin
        plen++;
        if (int'(cnt1) != pause_at) frozen_bad++;
      end
    end
    pause1 = 1'b0;
    chk({nm, "_frozen_bad"}, frozen_bad, 0);
    chk({nm, "_latency"}, cyc, t + 1 + 4);
    chk({nm, "_final_cnt"}, int'(cnt1), t);
    step();
    chk({nm, "_ready_after"}, {31'b0, ready1}, 1);
  endtask

  // P=3 job; returns accept-to-done latency, largest count seen and count at cycle 150.
  task automatic p3_job(input int t, output int lat, output int maxc, output int c150);
    start3  = 1'b1;
    target3 = 7'(t);
    step();
    start3 = 1'b0;
    lat = 0;
    maxc = int'(cnt3);
    c150 = -1;
    while (!done3 && lat < 400) begin
      step();
      lat++;
      if (int'(cnt3) > maxc) maxc = int'(cnt3);
      if (lat == 150) c150 = int'(cnt3);
    end
  endtask

  vec_t vecs[21];

  initial begin
    int lat, maxc, c150, cyc, n_done;

    vecs[0]  = mk(1,   5, 0, 0,  0, 0, 1, 0, 0);
    vecs[1]  = mk(0,   0, 0, 0,  1, 0, 1, 0, 0);
    vecs[2]  = mk(0,   0, 0, 0,  2, 0, 1, 0, 0);
    vecs[3]  = mk(1,   3, 0, 0,  3, 0, 1, 0, 0);
    vecs[4]  = mk(0,   0, 0, 0,  4, 0, 1, 0, 0);
    vecs[5]  = mk(0,   0, 0, 0,  5, 0, 1, 0, 0);
    vecs[6]  = mk(0,   0, 0, 0,  5, 0, 0, 1, 0);
    vecs[7]  = mk(0,   0, 0, 0,  5, 1, 0, 0, 0);
    vecs[8]  = mk(1, 100, 0, 0,  0, 1, 0, 0, 1);
    vecs[9]  = mk(0,   0, 0, 0,  0, 1, 0, 0, 0);
    vecs[10] = mk(1,   0, 0, 0,  0, 0, 1, 0, 0);
    vecs[11] = mk(0,   0, 0, 0,  0, 0, 0, 1, 0);
    vecs[12] = mk(0,   0, 0, 0,  0, 1, 0, 0, 0);
    vecs[13] = mk(1,  20, 0, 0,  0, 0, 1, 0, 0);
    vecs[14] = mk(0,   0, 0, 0,  1, 0, 1, 0, 0);
    vecs[15] = mk(0,   0, 1, 1,  0, 1, 0, 0, 0);
    vecs[16] = mk(0,   0, 0, 1,  0, 1, 0, 0, 0);
    vecs[17] = mk(1,   7, 0, 0,  0, 0, 1, 0, 0);
    vecs[18] = mk(0,   0, 1, 0,  0, 0, 1, 0, 0);
    vecs[19] = mk(0,   0, 0, 0,  1, 0, 1, 0, 0);
    vecs[20] = mk(0,   0, 0, 1,  0, 1, 0, 0, 0);

    reset = 1'b1;
    {start1, pause1, abort1, target1} = '0;
    {start3, pause3, abort3, target3} = '0;
    step();
    step();
    chk("rst_p1", {20'b0, cnt1, ready1, busy1, done1, err1}, {20'b0, 7'd0, 4'b1000});
    chk("rst_p3", {20'b0, cnt3, ready3, busy3, done3, err3}, {20'b0, 7'd0, 4'b1000});
    reset = 1'b0;
    step();

    for (int i = 0; i < 21; i++) begin
      start1  = vecs[i].start;
      target1 = vecs[i].target;
      pause1  = vecs[i].pause;
      abort1  = vecs[i].abort;
      step();
      chk($sformatf("vec%0d{cnt,rdy,busy,done,err}", i),
          {20'b0, cnt1, ready1, busy1, done1, err1},
          {20'b0, vecs[i].e_cnt, vecs[i].e_rdy, vecs[i].e_busy, vecs[i].e_done, vecs[i].e_err});
    end
    {start1, pause1, abort1, target1} = '0;
    step();

    pause_job(10, 6, "pause_mid");
    pause_job(10, 10, "pause_terminal");

    // Abort at o_cnt=20 with no done afterwards.
    start1  = 1'b1;
    target1 = 7'd30;
    step();
    start1 = 1'b0;
    cyc = 0;
    while (cnt1 != 7'd20 && cyc < 100) begin
      step();
      cyc++;
    end
    chk("abort_reach20", int'(cnt1), 20);
    abort1 = 1'b1;
    step();
    abort1 = 1'b0;
    chk("abort{cnt,rdy,busy}", {22'b0, cnt1, ready1, busy1}, {22'b0, 7'd0, 2'b10});
    n_done = 0;
    for (int i = 0; i < 5; i++) begin
      if (done1) n_done++;
      step();
    end
    chk("abort_no_done", n_done, 0);

    // Synchronous reset mid-RUN.
    start1  = 1'b1;
    target1 = 7'd50;
    step();
    start1 = 1'b0;
    cyc = 0;
    while (cnt1 != 7'd37 && cyc < 100) begin
      step();
      cyc++;
    end
    chk("rst_reach37", int'(cnt1), 37);
    reset = 1'b1;
    step();
    chk("rst_mid{cnt,rdy,busy,done}", {21'b0, cnt1, ready1, busy1, done1, err1},
        {21'b0, 7'd0, 4'b1000});
    step();
    reset = 1'b0;
    step();
    chk("rst_release{cnt,rdy,busy}", {22'b0, cnt1, ready1, busy1}, {22'b0, 7'd0, 2'b10});

    // Prescale 3 bounds.
    p3_job(99, lat, maxc, c150);
    chk("p3_t99_latency", lat, 300);
    chk("p3_t99_cnt", int'(cnt3), 99);
    chk("p3_t99_max", maxc, 99);
    chk("p3_t99_cnt_at150", c150, 50);
    step();
    chk("p3_t99_ready_after", {30'b0, ready3, err3}, 2);
    p3_job(0, lat, maxc, c150);
    chk("p3_t0_latency", lat, 3);
    chk("p3_t0_cnt", int'(cnt3), 0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cnt100_seq_ctrl.md
# cnt100_seq_ctrl

Sequencer for a modulo-100 count datapath. Accepts a count job (target value 0..99) over a valid/ready handshake, then advances a 7-bit count once every PRESCALE clocks until the target is reached. It supports pause and abort, and reports completion with a one-cycle done pulse. It sits between a host or control FSM and the 0~99 counter datapath, so the counter's enable and clear are always driven by one well-defined owner.

## Interface
- `MAX_CNT`, default 99: highest legal count and target value.
- `CNT_W`, default 7: count width; must satisfy 2^CNT_W > MAX_CNT.
- `PRESCALE`, default 1: clocks per count step, legal range 1..255.
- `clk`  in  1: single clock; all logic is on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `i_start`  in  1: job valid.
- `o_ready`  out  1: job ready; high only in IDLE.
- `i_target`  in  CNT_W: target count, sampled on accept.
- `i_pause`  in  1: level-sensitive; freezes the count while high.
- `i_abort`  in  1: one-cycle request to cancel the current job.
- `o_cnt`  out  CNT_W: current count (registered).
- `o_busy`  out  1: high in RUN or PAUSE.
- `o_done`  out  1: one-cycle pulse when a job completes.
- `o_err`  out  1: one-cycle pulse when a job is rejected.

## Operation
- **Reset values:** state=IDLE, o_cnt=0, prescaler=0, o_ready=1, o_busy=0, o_done=0, o_err=0.
- **States:**
  - IDLE: waits for a job.
  - RUN: counting.
  - PAUSE: count and prescaler frozen.
  - DONE: single cycle, o_done=1.
- **Accept:**
  - A job is accepted when i_start && o_ready.
  - On accept, i_target is latched and o_cnt is cleared to 0.
  - i_start while o_ready=0 is ignored, not queued.
- **Reject:**
  - If the accepted i_target > MAX_CNT, the block stays in IDLE and o_err pulses high in the next cycle.
  - o_cnt is still cleared.
- **IDLE→RUN:** on a legal accept; the prescaler is cleared to 0.
- **Tick:** occurs in RUN when prescaler == PRESCALE-1. The prescaler then wraps to 0; otherwise it increments.
- **RUN on tick:**
  - o_cnt < target: o_cnt increments by 1.
  - o_cnt == target: go to DONE; o_cnt holds.
- **PAUSE:**
  - RUN→PAUSE when i_pause=1. PAUSE→RUN when i_pause=0.
  - Prescaler and o_cnt are held in PAUSE.
- **DONE→IDLE:** unconditional, after one cycle. o_cnt holds the final value until the next accept.
- **Abort:** i_abort in RUN, PAUSE or DONE causes:
  - next state IDLE;
  - o_cnt=0 and prescaler=0;
  - no o_done pulse.
  - i_abort in IDLE has no effect.
- **Priority, highest first:** reset > i_abort > i_pause > tick.
  - i_pause on the terminal-tick cycle: the tick is suppressed, so completion is deferred.
- **Width rules:**
  - o_cnt is never above MAX_CNT.
  - The increment must not wrap, because target ≤ MAX_CNT is guaranteed.
  - A modulo wrap (MAX_CNT→0) is still implemented in the counter sub-module for reuse.

## Timing
- Accept happens at edge E0. o_cnt=0 and o_busy=1 after E0.
- With PRESCALE=P and target T:
  - o_cnt=k after edge E0+k·P.
  - DONE is entered at edge E0+(T+1)·P, with o_done high for that single cycle.
  - o_ready=1 again after edge E0+(T+1)·P+1.
- Job latency, accept to o_done: (T+1)·P cycles. T=0, P=1 gives o_done one cycle after accept.
- Each cycle spent in PAUSE adds exactly one cycle to this latency.
- o_err rises one cycle after the rejecting accept; o_ready stays 1 throughout.
- Abort is observed one cycle after i_abort: o_busy=0, o_ready=1, o_cnt=0.
- All outputs are registered or decoded from the state register only; there is no combinational input→output path.
- Back-to-back jobs: the earliest next accept is in the first IDLE cycle after DONE.

## Structure
- The shared package holds the FSM state encoding (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, DONE=2'd3) and default constants for MAX_CNT and CNT_W.
- One sub-module, `cnt100_core`, holds the counter. Its interface is:
  - clk, reset;
  - i_en (increment), i_clr (synchronous clear);
  - o_cnt, with modulo-(MAX_CNT+1) wrap.
- The controller owns the FSM, the prescaler, the target register and the handshake, and drives i_en/i_clr.

## Test plan
- **Reset:** assert reset for 2 cycles mid-RUN (o_cnt=37) → next cycle o_cnt=0, o_ready=1, o_busy=0, o_done=0.
- **Basic job:** P=1, start T=5 → o_cnt steps 0..5 on consecutive cycles; o_done pulses exactly once, 6 cycles after accept; o_cnt holds at 5; o_ready returns the next cycle.
- **Prescale and bounds:**
  - P=3, T=99 → o_done 300 cycles after accept, o_cnt=99, never 100.
  - T=0 → o_done 3 cycles after accept.
- **Pause:** P=1, T=10, hold i_pause for 4 cycles at o_cnt=6, including one case where pause is asserted on the terminal-tick cycle → o_cnt frozen at 6 while paused; completion delayed by exactly 4 cycles.
- **Abort and illegal start:**
  - i_abort at o_cnt=20 → IDLE, o_cnt=0, no o_done.
  - i_abort together with i_pause → abort wins.
  - i_start with T=100 → o_err pulses once and the block stays IDLE.
  - i_start during RUN → ignored.
